// File: rtl/score_scheduler.sv
// Score scheduler: serialises territory-count requests, waits for the counter
// and turns territory, captures and komi into half-point scores and a winner.
module score_scheduler #(
  parameter int unsigned KOMI_X2     = 13,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       move_req_in,
  input  logic       final_req_in,
  input  logic       new_game_in,
  input  logic [7:0] bcapt_in,
  input  logic [7:0] wcapt_in,
  output logic       terr_update_out,
  input  logic       terr_ready_in,
  input  logic [7:0] bterr_in,
  input  logic [7:0] wterr_in,
  output logic [9:0] bscore_x2_out,
  output logic [9:0] wscore_x2_out,
  output logic [1:0] winner_out,
  output logic       score_valid_out,
  output logic       final_out,
  output logic       busy_out,
  output logic       err_timeout_out
);

  localparam logic [9:0]  Komi   = 10'(KOMI_X2);
  localparam logic [15:0] CntMax = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAccum, StDone} state_e;

  state_e      state_q, state_d;
  logic        move_pend_q, move_pend_d;
  logic        final_pend_q, final_pend_d;
  logic        job_final_q, job_final_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  bterr_q, bterr_d, wterr_q, wterr_d;
  logic [7:0]  bcapt_q, bcapt_d, wcapt_q, wcapt_d;
  logic [9:0]  bscore_q, bscore_d, wscore_q, wscore_d;
  logic [1:0]  winner_q, winner_d;
  logic        final_q, final_d;
  logic        err_q, err_d;

  logic        move_req, final_req;
  logic [9:0]  bscore_calc, wscore_calc;

  // Once the final result is latched, further requests are ignored.
  assign move_req  = move_req_in & ~final_q;
  assign final_req = final_req_in & ~final_q;

  assign bscore_calc = 10'((10'(bterr_q) + 10'(bcapt_q)) << 1);
  assign wscore_calc = 10'((10'(wterr_q) + 10'(wcapt_q)) << 1) + Komi;

  always_comb begin
    state_d      = state_q;
    move_pend_d  = move_pend_q;
    final_pend_d = final_pend_q;
    job_final_d  = job_final_q;
    cnt_d        = cnt_q;
    bterr_d      = bterr_q;
    wterr_d      = wterr_q;
    bcapt_d      = bcapt_q;
    wcapt_d      = wcapt_q;
    bscore_d     = bscore_q;
    wscore_d     = wscore_q;
    winner_d     = winner_q;
    final_d      = final_q;
    err_d        = err_q;

    if (new_game_in) begin
      // Abort everything; same-cycle requests are dropped.
      state_d      = StIdle;
      move_pend_d  = 1'b0;
      final_pend_d = 1'b0;
      job_final_d  = 1'b0;
      cnt_d        = '0;
      bscore_d     = '0;
      wscore_d     = '0;
      winner_d     = '0;
      final_d      = 1'b0;
      err_d        = 1'b0;
    end else begin
      if (move_req)  move_pend_d  = 1'b1;
      if (final_req) final_pend_d = 1'b1;

      case (state_q)
        StIdle: begin
          if (final_pend_d || move_pend_d) begin
            state_d     = StIssue;
            job_final_d = final_pend_d;
            // A final job supersedes any outstanding move refresh.
            if (final_pend_d) final_pend_d = 1'b0;
            move_pend_d = 1'b0;
          end
        end
        StIssue: begin
          cnt_d   = '0;
          state_d = StWait;
        end
        StWait: begin
          if (terr_ready_in) begin
            bterr_d = bterr_in;
            wterr_d = wterr_in;
            bcapt_d = bcapt_in;
            wcapt_d = wcapt_in;
            state_d = StAccum;
          end else if (cnt_q == CntMax) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StAccum: begin
          bscore_d = bscore_calc;
          wscore_d = wscore_calc;
          if (bscore_calc > wscore_calc) begin
            winner_d = 2'b01;
          end else if (wscore_calc > bscore_calc) begin
            winner_d = 2'b10;
          end else begin
            winner_d = 2'b00;
          end
          state_d = StDone;
        end
        StDone: begin
          if (job_final_q) final_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      move_pend_q  <= 1'b0;
      final_pend_q <= 1'b0;
      job_final_q  <= 1'b0;
      cnt_q        <= '0;
      bterr_q      <= '0;
      wterr_q      <= '0;
      bcapt_q      <= '0;
      wcapt_q      <= '0;
      bscore_q     <= '0;
      wscore_q     <= '0;
      winner_q     <= '0;
      final_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_pend_q  <= move_pend_d;
      final_pend_q <= final_pend_d;
      job_final_q  <= job_final_d;
      cnt_q        <= cnt_d;
      bterr_q      <= bterr_d;
      wterr_q      <= wterr_d;
      bcapt_q      <= bcapt_d;
      wcapt_q      <= wcapt_d;
      bscore_q     <= bscore_d;
      wscore_q     <= wscore_d;
      winner_q     <= winner_d;
      final_q      <= final_d;
      err_q        <= err_d;
    end
  end

  // Decoded straight from the state register so async reset drops them at once.
  assign terr_update_out = (state_q == StIssue);
  assign score_valid_out = (state_q == StDone);
  assign busy_out        = (state_q != StIdle);
  assign bscore_x2_out   = bscore_q;
  assign wscore_x2_out   = wscore_q;
  assign winner_out      = winner_q;
  assign final_out       = final_q;
  assign err_timeout_out = err_q;

endmodule

// File: tb/tb_score_scheduler.sv
// Bench for score_scheduler: two instances (komi 6.5 and komi 0), a ready
// responder feeding a scoreboard, and a monitor that checks each score_valid.
module tb_score_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_req = 1'b0, final_req = 1'b0, new_game = 1'b0, terr_ready = 1'b0;
  logic [7:0] bcapt = '0, wcapt = '0, bterr = '0, wterr = '0;

  logic       upd_a, val_a, fin_a, busy_a, err_a;
  logic [9:0] bs_a, ws_a;
  logic [1:0] win_a;
  logic       upd_b, val_b, fin_b, busy_b, err_b;
  logic [9:0] bs_b, ws_b;
  logic [1:0] win_b;

  int checks = 0, errors = 0, cyc = 0, upd_cnt = 0, val_cnt = 0;
  bit upd_prev = 1'b0;
  bit resp_mute = 1'b0, resp_rand = 1'b0;
  int resp_delay = 1;
  logic [7:0] resp_b = '0, resp_w = '0;

  typedef struct {int b; int w13; int w0; int rdy;} exp_t;
  exp_t sb[$];

  score_scheduler #(.KOMI_X2(13), .TIMEOUT_CYC(8)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .move_req_in(move_req), .final_req_in(final_req),
    .new_game_in(new_game), .bcapt_in(bcapt), .wcapt_in(wcapt), .terr_update_out(upd_a),
    .terr_ready_in(terr_ready), .bterr_in(bterr), .wterr_in(wterr), .bscore_x2_out(bs_a),
    .wscore_x2_out(ws_a), .winner_out(win_a), .score_valid_out(val_a), .final_out(fin_a),
    .busy_out(busy_a), .err_timeout_out(err_a)
  );

  score_scheduler #(.KOMI_X2(0), .TIMEOUT_CYC(8)) u_dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .move_req_in(move_req), .final_req_in(final_req),
    .new_game_in(new_game), .bcapt_in(bcapt), .wcapt_in(wcapt), .terr_update_out(upd_b),
    .terr_ready_in(terr_ready), .bterr_in(bterr), .wterr_in(wterr), .bscore_x2_out(bs_b),
    .wscore_x2_out(ws_b), .winner_out(win_b), .score_valid_out(val_b), .final_out(fin_b),
    .busy_out(busy_b), .err_timeout_out(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int win_of(int b, int w);
    return (b > w) ? 1 : ((w > b) ? 2 : 0);
  endfunction

  // Territory counter model: answers each update pulse after a delay.
  initial begin
    forever begin
      @(negedge clk);
      if (upd_a === 1'b1 && !resp_mute) begin
        int d;
        exp_t e;
        d = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
        repeat (d) @(posedge clk);
        #1;
        if (resp_rand) begin
          bterr = 8'($urandom);
          wterr = 8'($urandom);
        end else begin
          bterr = resp_b;
          wterr = resp_w;
        end
        terr_ready = 1'b1;
        e.b   = 2 * (int'(bterr) + int'(bcapt));
        e.w0  = 2 * (int'(wterr) + int'(wcapt));
        e.w13 = e.w0 + 13;
        e.rdy = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 terr_ready = 1'b0;
      end
    end
  end

  // Monitor: every score_valid must match the oldest scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (upd_a) begin
        upd_cnt++;
        chk("update_single_cycle", 32'(upd_prev), 0);
        chk("update_inst_match", 32'(upd_b), 1);
      end
      if (val_a) begin
        val_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got score_valid=1, required 0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bscore_k13", 32'(bs_a), e.b);
          chk("wscore_k13", 32'(ws_a), e.w13);
          chk("winner_k13", 32'(win_a), win_of(e.b, e.w13));
          chk("bscore_k0", 32'(bs_b), e.b);
          chk("wscore_k0", 32'(ws_b), e.w0);
          chk("winner_k0", 32'(win_b), win_of(e.b, e.w0));
          chk("valid_k0", 32'(val_b), 1);
          chk("ready_to_valid_latency", cyc - e.rdy, 2);
        end
      end
      upd_prev = upd_a;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_move();
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
  endtask

  task automatic pulse_final();
    final_req = 1'b1;
    tick();
    final_req = 1'b0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      tick();
      if (!busy_a) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1 after 300 cycles, required idle");
    end
  endtask

  initial begin
    int u0, v0, c0, t_err;

    tick(2);
    chk("rst_update", 32'(upd_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_valid", 32'(val_a), 0);
    chk("rst_scores", 32'({bs_a, ws_a, win_a}), 0);
    chk("rst_final", 32'(fin_a), 0);
    chk("rst_err", 32'(err_a), 0);
    rst_n = 1'b1;
    tick(2);

    // Single move job.
    bcapt = 8'd3; wcapt = 8'd2; resp_b = 8'd20; resp_w = 8'd15; resp_delay = 5;
    u0 = upd_cnt; v0 = val_cnt;
    pulse_move();
    wait_idle();
    chk("t1_updates", upd_cnt - u0, 1);
    chk("t1_valids", val_cnt - v0, 1);
    chk("t1_bscore", 32'(bs_a), 46);
    chk("t1_wscore", 32'(ws_a), 47);
    chk("t1_winner", 32'(win_a), 2);
    chk("t1_final", 32'(fin_a), 0);

    // Coalesced moves plus a final during WAIT give exactly one extra (final) job.
    bcapt = 8'd0; wcapt = 8'd0; resp_b = 8'd30; resp_w = 8'd20; resp_delay = 6;
    u0 = upd_cnt; v0 = val_cnt;
    pulse_move();
    tick();
    pulse_move(); pulse_move(); pulse_move();
    pulse_final();
    wait_idle();
    chk("t2_updates", upd_cnt - u0, 2);
    chk("t2_valids", val_cnt - v0, 2);
    chk("t2_bscore", 32'(bs_a), 60);
    chk("t2_wscore", 32'(ws_a), 53);
    chk("t2_winner", 32'(win_a), 1);
    chk("t2_final", 32'(fin_a), 1);
    u0 = upd_cnt;
    pulse_move();
    pulse_final();
    tick(15);
    chk("t2_ignored_after_final", upd_cnt - u0, 0);
    chk("t2_final_held", 32'(fin_a), 1);

    pulse_new_game();
    chk("ng_final", 32'(fin_a), 0);
    chk("ng_scores", 32'({bs_a, ws_a, win_a}), 0);

    // Normal job, then a timeout that must keep those scores.
    bcapt = 8'd5; wcapt = 8'd7; resp_b = 8'd40; resp_w = 8'd33; resp_delay = 2;
    pulse_move();
    wait_idle();
    resp_mute = 1'b1;
    v0 = val_cnt;
    c0 = cyc;
    pulse_move();
    t_err = -1;
    for (int i = 0; i < 40 && t_err < 0; i++) begin
      if (err_a) t_err = cyc;
      else tick();
    end
    chk("to_err_set", 32'(err_a), 1);
    chk("to_latency", t_err - c0, 10);
    tick();
    chk("to_busy", 32'(busy_a), 0);
    chk("to_no_valid", val_cnt - v0, 0);
    chk("to_bscore_kept", 32'(bs_a), 90);
    chk("to_wscore_kept", 32'(ws_a), 93);
    resp_mute = 1'b0;

    // Tie on the komi-0 instance; also serves the request after a timeout.
    bcapt = 8'd0; wcapt = 8'd0; resp_b = 8'd10; resp_w = 8'd10; resp_delay = 3;
    v0 = val_cnt;
    pulse_move();
    wait_idle();
    chk("tie_valid", val_cnt - v0, 1);
    chk("tie_bscore", 32'(bs_b), 20);
    chk("tie_wscore", 32'(ws_b), 20);
    chk("tie_winner", 32'(win_b), 0);
    chk("tie_err_sticky", 32'(err_a), 1);

    // new_game during WAIT, then a late ready that must be ignored.
    resp_mute = 1'b1;
    pulse_move();
    tick(3);
    chk("ngw_busy_before", 32'(busy_a), 1);
    pulse_new_game();
    chk("ngw_scores", 32'({bs_a, ws_a, win_a}), 0);
    chk("ngw_flags", 32'({fin_a, err_a, busy_a}), 0);
    v0 = val_cnt; u0 = upd_cnt;
    bterr = 8'd50; terr_ready = 1'b1;
    tick();
    terr_ready = 1'b0;
    tick(10);
    chk("ngw_no_valid", val_cnt - v0, 0);
    chk("ngw_idle", 32'(busy_a), 0);
    chk("ngw_scores_late", 32'(bs_a), 0);
    move_req = 1'b1; new_game = 1'b1;
    tick();
    move_req = 1'b0; new_game = 1'b0;
    tick(5);
    chk("ngw_req_dropped", upd_cnt - u0, 0);
    resp_mute = 1'b0;

    // Async reset between edges while in ISSUE.
    pulse_move();
    chk("ar_in_issue", 32'(upd_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_update_drop", 32'(upd_a), 0);
    chk("ar_busy_drop", 32'(busy_a), 0);
    #3 rst_n = 1'b1;
    tick(2);
    chk("ar_busy_after", 32'(busy_a), 0);
    bcapt = 8'd9; wcapt = 8'd1; resp_b = 8'd7; resp_w = 8'd12; resp_delay = 4;
    v0 = val_cnt;
    pulse_move();
    wait_idle();
    chk("ar_job_after", val_cnt - v0, 1);

    // Randomised move traffic with occasional back-to-back requests.
    resp_rand = 1'b1;
    u0 = upd_cnt; v0 = val_cnt;
    for (int i = 0; i < 25; i++) begin
      bcapt = 8'($urandom);
      wcapt = 8'($urandom);
      pulse_move();
      if ($urandom_range(0, 1) == 1) begin
        tick(int'($urandom_range(1, 4)));
        pulse_move();
      end
      wait_idle();
    end
    chk("rand_jobs_completed", val_cnt - v0, upd_cnt - u0);
    chk("rand_scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
